wave_cmd_player: RTL and testbench

- Single-clock stage between the SPI slave's 32-bit word output and the AD9744 data bus `wd`.
- Decodes command words, stores 14-bit waveform samples in an internal RAM, and plays the table back cyclically with a programmable sample-hold divider.
- Reports malformed commands.

---
 rtl/wave_cmd_player.sv | 160 ++++++++++++++++
 tb/tb_wave_cmd_player.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wave_cmd_player.sv
// rtl/wave_cmd_player.sv - SPI command decoder, waveform RAM and cyclic DAC sample player
// Define WAVE_IDLE_MIDSCALE_EN to park wd at DAC midscale instead of zero when idle.
module wave_cmd_player #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   rx_data,
    input  logic          rx_valid,
    output logic [DW-1:0] wd,
    output logic          wd_valid,
    output logic          running,
    output logic          cmd_err,
    output logic [7:0]    err_count
);

`ifdef WAVE_IDLE_MIDSCALE_EN
    localparam logic [DW-1:0] IDLE_VAL = {1'b1, {(DW-1){1'b0}}};
`else
    localparam logic [DW-1:0] IDLE_VAL = '0;
`endif
    localparam logic [14:0] DEPTH_W = 15'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_PLAY} state_t;

    state_t        state, state_nxt;
    logic [14:0]   len, len_next;
    logic [15:0]   div, div_next;
    logic [15:0]   cnt;
    logic [AW-1:0] idx, idx_nxt;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] mem [DEPTH];

    logic [3:0]  opcode;
    logic [13:0] arg;
    logic [14:0] arg_w;
    logic        do_write, do_start, do_stop, do_len, do_div, reject;
    logic        tick, wrap, ram_re, idx_last;

    assign opcode   = rx_data[31:28];
    assign arg      = rx_data[27:14];
    assign arg_w    = {1'b0, arg};
    assign idx_last = (15'(idx) == len - 15'd1);

    always_comb begin
        do_write = 1'b0;
        do_start = 1'b0;
        do_stop  = 1'b0;
        do_len   = 1'b0;
        do_div   = 1'b0;
        reject   = 1'b0;
        if (rx_valid) begin
            case (opcode)
                4'h1: if (arg_w < DEPTH_W) do_write = 1'b1; else reject = 1'b1;
                4'h2: do_start = 1'b1;
                4'h3: do_stop  = 1'b1;
                4'h4: if (arg == 14'd0 || arg_w > DEPTH_W) reject = 1'b1; else do_len = 1'b1;
                4'h5: do_div   = 1'b1;
                default: reject = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (do_stop)               state_nxt = S_IDLE;
        else if (do_start)         state_nxt = S_PRIME;
        else if (state == S_PRIME) state_nxt = S_PLAY;
    end

    // A STOP or START in a sample cycle suppresses that sample.
    always_comb begin
        tick      = 1'b0;
        wrap      = 1'b0;
        ram_re    = 1'b0;
        ram_raddr = '0;
        idx_nxt   = idx;
        running   = (state != S_IDLE);
        case (state)
            S_PRIME: ram_re = 1'b1;
            S_PLAY: begin
                if (cnt == 16'd0 && !do_stop && !do_start) begin
                    tick      = 1'b1;
                    wrap      = idx_last;
                    idx_nxt   = idx_last ? '0 : idx + AW'(1);
                    ram_re    = 1'b1;
                    ram_raddr = idx_nxt;
                end
            end
            default: ;
        endcase
    end

    // ram_q always holds the sample that the next tick will present.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len      <= DEPTH_W;
            len_next <= DEPTH_W;
            div      <= '0;
            div_next <= '0;
            cnt      <= '0;
            idx      <= '0;
        end else begin
            if (do_len) len_next <= arg_w;
            if (do_div) div_next <= rx_data[15:0];
            if (state == S_PRIME) begin
                len <= len_next;
                div <= div_next;
                cnt <= '0;
                idx <= '0;
            end else if (tick) begin
                idx <= idx_nxt;
                if (wrap) begin
                    len <= len_next;
                    div <= div_next;
                    cnt <= div_next;
                end else begin
                    cnt <= div;
                end
            end else if (state == S_PLAY && cnt != 16'd0) begin
                cnt <= cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd        <= IDLE_VAL;
            wd_valid  <= 1'b0;
            cmd_err   <= 1'b0;
            err_count <= '0;
        end else begin
            if (do_stop) begin
                wd       <= IDLE_VAL;
                wd_valid <= 1'b0;
            end else if (tick) begin
                wd       <= ram_q;
                wd_valid <= 1'b1;
            end else begin
                wd_valid <= 1'b0;
            end
            cmd_err <= reject;
            if (reject && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[arg[AW-1:0]] <= rx_data[DW-1:0];
        if (ram_re)   ram_q <= mem[ram_raddr];
    end

endmodule

// File: tb/tb_wave_cmd_player.sv
// tb/tb_wave_cmd_player.sv - directed bench with a cycle-level behavioural model of wave_cmd_player
module tb_wave_cmd_player;

    localparam int DEPTH = 256;
`ifdef WAVE_IDLE_MIDSCALE_EN
    localparam logic [13:0] IDLE_V = 14'h2000;
`else
    localparam logic [13:0] IDLE_V = 14'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [13:0] wd;
    logic        wd_valid, running, cmd_err;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;

    wave_cmd_player dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .wd(wd), .wd_valid(wd_valid), .running(running),
        .cmd_err(cmd_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Model: table playback expressed as absolute cycle numbers of the next sample.
    logic [13:0] m_mem [DEPTH];
    int          n = 0;
    int          m_next, m_pos, m_len, m_len_n, m_div, m_div_n, e_cnt;
    logic        m_run, m_prime, e_valid, e_err;
    logic [13:0] e_wd;

    task automatic model_reset();
        m_run = 0; m_prime = 0; m_pos = 0; m_next = 0;
        m_len = DEPTH; m_len_n = DEPTH; m_div = 0; m_div_n = 0;
        e_wd = IDLE_V; e_valid = 0; e_err = 0; e_cnt = 0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] d);
        int  op, a;
        logic rej;
        op = int'(d[31:28]);
        a  = int'(d[27:14]);
        rej = 0;
        e_valid = 0;
        n++;
        if (m_prime) begin
            m_len = m_len_n; m_div = m_div_n; m_prime = 0; m_next = n + 1;
        end else if (m_run && n == m_next && !(v && (op == 2 || op == 3))) begin
            e_wd = m_mem[m_pos];
            e_valid = 1;
            if (m_pos == m_len - 1) begin
                m_pos = 0; m_len = m_len_n; m_div = m_div_n;
            end else begin
                m_pos++;
            end
            m_next = n + m_div + 1;
        end
        if (v) begin
            case (op)
                1: if (a < DEPTH) m_mem[a] = d[13:0]; else rej = 1;
                2: begin m_run = 1; m_prime = 1; m_pos = 0; end
                3: begin m_run = 0; m_prime = 0; e_wd = IDLE_V; end
                4: if (a == 0 || a > DEPTH) rej = 1; else m_len_n = a;
                5: m_div_n = int'(d[15:0]);
                default: rej = 1;
            endcase
        end
        e_err = rej;
        if (rej && e_cnt < 255) e_cnt++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(v, d);
        #1;
        rx_valid = 1'b0;
        rx_data  = '0;
        chk("wd", 32'(wd), 32'(e_wd));
        chk("wd_valid", 32'(wd_valid), 32'(e_valid));
        chk("running", 32'(running), 32'(m_run));
        chk("cmd_err", 32'(cmd_err), 32'(e_err));
        chk("err_count", 32'(err_count), 32'(e_cnt));
    endtask

    task automatic send(input logic [3:0] op, input logic [13:0] a, input logic [13:0] d);
        cyc(1'b1, {op, a, d});
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 32'h0);
    endtask

    logic [13:0] seq1 [5];

    initial begin
        seq1[0] = 14'h10; seq1[1] = 14'h20; seq1[2] = 14'h30; seq1[3] = 14'h40; seq1[4] = 14'h10;
        model_reset();
        cyc(1'b0, 32'h0);
        chk("reset_wd", 32'(wd), 32'(IDLE_V));
        chk("reset_running", 32'(running), 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < DEPTH; i++) send(4'h1, 14'(i), 14'(i * 3 + 5));
        for (int i = 0; i < 4; i++) send(4'h1, 14'(i), 14'(16 * (i + 1)));
        send(4'h4, 14'd4, 14'd0);

        send(4'h2, 14'd0, 14'd0);
        chk("start_running", 32'(running), 32'd1);
        chk("start_valid0", 32'(wd_valid), 32'd0);
        idle(1);
        chk("prime_valid0", 32'(wd_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("play_seq_wd", 32'(wd), 32'(seq1[i]));
            chk("play_seq_valid", 32'(wd_valid), 32'd1);
        end

        cyc(1'b1, {4'h5, 12'h000, 16'd2});
        chk("div_pre_wrap_a", 32'(wd), 32'h20);
        idle(1);
        chk("div_pre_wrap_b", 32'(wd), 32'h30);
        idle(1);
        chk("div_pre_wrap_c", 32'(wd), 32'h40);
        idle(1);
        chk("div_gap_1", 32'(wd_valid), 32'd0);
        idle(1);
        chk("div_gap_2", 32'(wd_valid), 32'd0);
        idle(1);
        chk("div_post_wrap_wd", 32'(wd), 32'h10);
        chk("div_post_wrap_valid", 32'(wd_valid), 32'd1);
        idle(7);

        send(4'h7, 14'd0, 14'd0);
        chk("bad_op_err", 32'(cmd_err), 32'd1);
        send(4'h1, 14'd300, 14'h3FFF);
        send(4'h4, 14'd0, 14'd0);
        chk("three_rejects", 32'(err_count), 32'd3);
        idle(1);
        chk("err_pulse_end", 32'(cmd_err), 32'd0);
        send(4'h1, 14'd256, 14'h1234);
        send(4'h4, 14'd257, 14'd0);
        chk("boundary_rejects", 32'(err_count), 32'd5);
        send(4'h4, 14'd4, 14'd0);
        chk("len_4_accepted", 32'(cmd_err), 32'd0);
        for (int i = 0; i < 300; i++) send(4'h0, 14'(i), 14'd0);
        chk("err_saturated", 32'(err_count), 32'd255);
        chk("err_pulse_saturated", 32'(cmd_err), 32'd1);
        idle(2);

        send(4'h3, 14'd0, 14'd0);
        chk("stop_running", 32'(running), 32'd0);
        chk("stop_wd", 32'(wd), 32'(IDLE_V));
        idle(3);
        send(4'h2, 14'd0, 14'd0);
        idle(2);
        chk("restart_wd", 32'(wd), 32'h10);
        chk("restart_valid", 32'(wd_valid), 32'd1);
        idle(7);

        rst = 1'b1;
        #1;
        chk("async_rst_wd", 32'(wd), 32'(IDLE_V));
        chk("async_rst_running", 32'(running), 32'd0);
        chk("async_rst_valid", 32'(wd_valid), 32'd0);
        chk("async_rst_err_count", 32'(err_count), 32'd0);
        model_reset();
        idle(2);
        rst = 1'b0;
        idle(1);

        send(4'h2, 14'd0, 14'd0);
        idle(2);
        chk("replay_mem0", 32'(wd), 32'h10);
        idle(4);
        chk("replay_mem4", 32'(wd), 32'h11);
        idle(256);
        send(4'h3, 14'd0, 14'd0);
        chk("stop_beats_sample", 32'(wd_valid), 32'd0);
        chk("stop_beats_sample_wd", 32'(wd), 32'(IDLE_V));
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
